// File: rtl/microwave_ctrl.sv
// Microwave sequencer: keypad entry buffer, cook/pause/done FSM, timer control.
// Optional CTRL_QUICKSTART_EN: start with an empty buffer loads 00:30 and cooks.
module microwave_ctrl #(
  parameter int NDIGITS   = 4,
  parameter int DONE_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           key_d,
  input  logic                 key_loadn,
  input  logic                 start,
  input  logic                 stop_clear,
  input  logic                 door_closed,
  input  logic                 timer_zero,
  output logic                 key_enablen,
  output logic [4*NDIGITS-1:0] digits,
  output logic                 timer_load,
  output logic                 timer_en,
  output logic                 magnetron_on,
  output logic                 done
);

  localparam int W  = 4 * NDIGITS;
  localparam int CW = (DONE_HOLD > 1) ? $clog2(DONE_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(DONE_HOLD - 1);
`ifdef CTRL_QUICKSTART_EN
  localparam logic [W-1:0] QS_LOAD = W'(8'h30);
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COOK  = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_q;
  logic [W-1:0]    digits_q;
  logic [CW-1:0]   hold_q;
  logic            key_loadn_q;
  logic            timer_load_q;

  logic key_edge;
  logic key_ok;
  logic go;

  // One capture per press: only the high-to-low transition of the strobe.
  assign key_edge = key_loadn_q & ~key_loadn;
  assign key_ok   = (key_d <= 4'd9);
  assign go       = start & door_closed;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      digits_q     <= '0;
      hold_q       <= '0;
      key_loadn_q  <= 1'b1;
      timer_load_q <= 1'b0;
    end else begin
      key_loadn_q  <= key_loadn;
      timer_load_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (stop_clear) begin
            digits_q <= '0;
          end else begin
            if (key_edge && key_ok) begin
              digits_q <= {digits_q[W-5:0], key_d};
            end
            // Start decision uses the buffer as it stood before this edge.
            if (go && (digits_q != '0)) begin
              state_q      <= COOK;
              timer_load_q <= 1'b1;
            end
`ifdef CTRL_QUICKSTART_EN
            else if (go) begin
              digits_q     <= QS_LOAD;
              state_q      <= COOK;
              timer_load_q <= 1'b1;
            end
`endif
          end
        end
        COOK: begin
          if (timer_zero) begin
            state_q <= DONE;
          end else if (stop_clear || !door_closed) begin
            state_q <= PAUSE;
          end
        end
        PAUSE: begin
          if (stop_clear) begin
            state_q  <= IDLE;
            digits_q <= '0;
          end else if (go) begin
            state_q <= COOK;
          end
        end
        DONE: begin
          if (stop_clear || (hold_q == HOLD_LAST)) begin
            state_q  <= IDLE;
            digits_q <= '0;
            hold_q   <= '0;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign key_enablen  = (state_q != IDLE);
  assign timer_en     = (state_q == COOK);
  assign magnetron_on = (state_q == COOK);
  assign done         = (state_q == DONE);
  assign timer_load   = timer_load_q;
  assign digits       = digits_q;

endmodule

// File: tb/tb_microwave_ctrl.sv
// Directed vector bench for microwave_ctrl.
// Each row is one clock: inputs driven, outputs checked after the edge.
module tb_microwave_ctrl;

  logic        clk;
  logic        rst;
  logic [3:0]  key_d;
  logic        key_loadn;
  logic        start;
  logic        stop_clear;
  logic        door_closed;
  logic        timer_zero;
  logic        key_enablen;
  logic [15:0] digits;
  logic        timer_load;
  logic        timer_en;
  logic        magnetron_on;
  logic        done;

  microwave_ctrl #(.NDIGITS(4), .DONE_HOLD(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .key_d        (key_d),
    .key_loadn    (key_loadn),
    .start        (start),
    .stop_clear   (stop_clear),
    .door_closed  (door_closed),
    .timer_zero   (timer_zero),
    .key_enablen  (key_enablen),
    .digits       (digits),
    .timer_load   (timer_load),
    .timer_en     (timer_en),
    .magnetron_on (magnetron_on),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // out = {key_enablen, timer_load, timer_en, magnetron_on, done}
  localparam logic [4:0] O_I = 5'b00000;
  localparam logic [4:0] O_L = 5'b11110;
  localparam logic [4:0] O_C = 5'b10110;
  localparam logic [4:0] O_P = 5'b10000;
  localparam logic [4:0] O_D = 5'b10001;

  typedef struct {
    logic        r;
    logic [3:0]  kd;
    logic        kl;
    logic        st;
    logic        sc;
    logic        dc;
    logic        tz;
    logic [15:0] dg;
    logic [4:0]  o;
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   bad   = 0;

  function automatic void add(logic r, logic [3:0] kd, logic kl,
                              logic st, logic sc, logic dc,
                              logic tz, logic [15:0] dg,
                              logic [4:0] o);
    vec_t v;
    v.r = r; v.kd = kd; v.kl = kl; v.st = st; v.sc = sc;
    v.dc = dc; v.tz = tz; v.dg = dg; v.o = o;
    vq.push_back(v);
  endfunction

  // idle-input row
  function automatic void nop(logic [15:0] dg, logic [4:0] o);
    add(0, 4'd0, 1, 0, 0, 1, 0, dg, o);
  endfunction

  // key press low row then release row
  function automatic void key(logic [3:0] kd, logic [15:0] dg);
    add(0, kd, 0, 0, 0, 1, 0, dg, O_I);
    add(0, kd, 1, 0, 0, 1, 0, dg, O_I);
  endfunction

  task automatic run(input vec_t v, input int idx);
    logic [4:0] got;
    @(negedge clk);
    rst = v.r; key_d = v.kd; key_loadn = v.kl; start = v.st;
    stop_clear = v.sc; door_closed = v.dc; timer_zero = v.tz;
    @(posedge clk);
    #1;
    got = {key_enablen, timer_load, timer_en, magnetron_on, done};
    total++;
    if (digits !== v.dg) begin
      bad++;
      $display("FAIL row%0d digits: got %h want %h", idx, digits, v.dg);
    end
    total++;
    if (got !== v.o) begin
      bad++;
      $display("FAIL row%0d outs{ken,ld,en,mag,done}: got %b want %b",
               idx, got, v.o);
    end
  endtask

  initial begin
    rst = 1; key_d = 0; key_loadn = 1; start = 0;
    stop_clear = 0; door_closed = 1; timer_zero = 0;

    // --- table ---
    add(1, 4'd0, 1, 0, 0, 1, 0, 16'h0000, O_I);
    add(0, 4'd1, 0, 0, 0, 1, 0, 16'h0001, O_I);
    add(0, 4'd1, 0, 0, 0, 1, 0, 16'h0001, O_I);
    nop(16'h0001, O_I);
    add(0, 4'd3, 0, 0, 0, 1, 0, 16'h0013, O_I);
    add(0, 4'd3, 0, 0, 0, 1, 0, 16'h0013, O_I);
    nop(16'h0013, O_I);
    key(4'd0, 16'h0130);
    add(0, 4'd0, 1, 1, 0, 0, 0, 16'h0130, O_I);
    add(0, 4'd0, 1, 1, 0, 1, 0, 16'h0130, O_L);
    nop(16'h0130, O_C);
    add(0, 4'd0, 1, 0, 0, 0, 0, 16'h0130, O_P);
    add(0, 4'd0, 1, 1, 0, 1, 0, 16'h0130, O_C);
    nop(16'h0130, O_C);
    add(0, 4'd0, 1, 0, 1, 1, 0, 16'h0130, O_P);
    add(0, 4'd0, 1, 0, 1, 1, 0, 16'h0000, O_I);
    key(4'd1, 16'h0001);
    key(4'd2, 16'h0012);
    key(4'd3, 16'h0123);
    key(4'd4, 16'h1234);
    key(4'd5, 16'h2345);
    for (int i = 0; i < 10; i++)
      add(0, 4'd7, 0, 0, 0, 1, 0, 16'h3457, O_I);
    nop(16'h3457, O_I);
    key(4'hA, 16'h3457);
    add(0, 4'd0, 1, 1, 0, 1, 0, 16'h3457, O_L);
    add(0, 4'd0, 1, 0, 0, 0, 1, 16'h3457, O_D);
    for (int i = 0; i < 7; i++)
      add(0, 4'd0, 1, (i == 3), 0, 1, 0, 16'h3457, O_D);
    nop(16'h0000, O_I);
    key(4'd5, 16'h0005);
    add(0, 4'd0, 1, 1, 1, 1, 0, 16'h0000, O_I);
`ifdef CTRL_QUICKSTART_EN
    add(0, 4'd0, 1, 1, 0, 1, 0, 16'h0030, O_L);
    nop(16'h0030, O_C);
    add(0, 4'd0, 1, 0, 1, 1, 0, 16'h0030, O_P);
    add(0, 4'd0, 1, 0, 1, 1, 0, 16'h0000, O_I);
`else
    add(0, 4'd0, 1, 1, 0, 1, 0, 16'h0000, O_I);
    nop(16'h0000, O_I);
`endif

    foreach (vq[i]) run(vq[i], i);

    // --- key held across DONE->IDLE, early stop in DONE, reset mid-cook ---
    vq.delete();
    key(4'd9, 16'h0009);
    add(0, 4'd0, 1, 1, 0, 1, 0, 16'h0009, O_L);
    add(0, 4'd0, 1, 0, 0, 1, 1, 16'h0009, O_D);
    add(0, 4'd4, 0, 0, 0, 1, 0, 16'h0009, O_D);
    add(0, 4'd4, 0, 0, 1, 1, 0, 16'h0000, O_I);
    add(0, 4'd4, 0, 0, 0, 1, 0, 16'h0000, O_I);
    add(0, 4'd4, 0, 0, 0, 1, 0, 16'h0000, O_I);
    nop(16'h0000, O_I);
    add(0, 4'd4, 0, 0, 0, 1, 0, 16'h0004, O_I);
    add(0, 4'd4, 1, 1, 0, 1, 0, 16'h0004, O_L);
    nop(16'h0004, O_C);
    add(1, 4'd0, 1, 0, 0, 1, 0, 16'h0000, O_I);
    nop(16'h0000, O_I);

    foreach (vq[i]) run(vq[i], 1000 + i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
